// File: rtl/bfp16_pkg.sv
// Shared BFP16 definitions for the matmul datapath: field widths, special
// encodings and the accumulator state machine encoding.
package bfp16_pkg;
  localparam int DATA_W = 16;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;

  localparam logic [EXP_W-1:0]  BIAS    = 8'd127;
  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [DATA_W-1:0] QNAN    = 16'hFFFF;
  localparam logic [DATA_W-1:0] PINF    = 16'h7F80;
  localparam logic [DATA_W-1:0] NINF    = 16'hFF80;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ALIGN = 2'd1,
    S_NORM  = 2'd2,
    S_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/bfp16_lzc.sv
// Leading-zero counter: returns the number of zero bits above the most
// significant set bit of din, or W when din is all zeros.
module bfp16_lzc #(
  parameter int W  = 17,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count
);
  always_comb begin
    count = CW'(W);
    // Scanning upward lets the highest set bit have the final say.
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/bfp16_accum.sv
// BFP16 dot-product accumulator: sums a stream of products into a
// wide-mantissa running sum and emits the truncated BFP16 result on last.
module bfp16_accum
  import bfp16_pkg::*;
#(
  parameter int ACC_M_W = 16,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CNT_W-1:0]  out_count,
  output state_t            dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in S_WAIT, out_valid only in S_OUT, and the
  // result stays stable until the consumer takes it.

  localparam int GUARD_W = ACC_M_W - FRAC_W - 1;
  localparam int LZ_W    = $clog2(ACC_M_W + 2);

  state_t state_q, state_d;

  logic [15:0]         lat_data;
  logic                lat_last;
  logic                acc_sign;
  logic [EXP_W-1:0]    acc_exp;
  logic [ACC_M_W-1:0]  acc_mant;
  logic                a_sign, b_sign;
  logic [ACC_M_W-1:0]  a_mant, b_mant;
  logic [EXP_W-1:0]    r_exp;
  logic                nan_flag, inf_flag, inf_sign;
  logic [CNT_W-1:0]    count;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ALIGN;
      end
      S_ALIGN: state_d = S_NORM;
      S_NORM:  state_d = lat_last ? S_OUT : S_WAIT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Alignment: specials contribute no mantissa, they only raise flags.
  logic                op_sign, op_nan, op_inf;
  logic [EXP_W-1:0]    op_exp, op_eff, acc_eff, diff, al_exp;
  logic [FRAC_W-1:0]   op_frac;
  logic [ACC_M_W-1:0]  op_mant, al_acc, al_op;

  always_comb begin
    op_sign = lat_data[15];
    op_exp  = lat_data[14:7];
    op_frac = lat_data[6:0];
    op_nan  = (op_exp == EXP_MAX) && (op_frac != '0);
    op_inf  = (op_exp == EXP_MAX) && (op_frac == '0);
    op_mant = {(op_exp != '0), op_frac, {GUARD_W{1'b0}}};
    op_eff  = (op_exp == '0) ? 8'd1 : op_exp;
    if (op_exp == EXP_MAX) begin
      op_mant = '0;
      op_eff  = 8'd1;
    end
    acc_eff = (acc_exp == '0) ? 8'd1 : acc_exp;
    if (op_eff > acc_eff) begin
      diff   = op_eff - acc_eff;
      al_op  = op_mant;
      al_acc = (diff >= 8'(ACC_M_W)) ? '0 : (acc_mant >> diff);
      al_exp = op_eff;
    end else begin
      diff   = acc_eff - op_eff;
      al_acc = acc_mant;
      al_op  = (diff >= 8'(ACC_M_W)) ? '0 : (op_mant >> diff);
      al_exp = acc_eff;
    end
  end

  // Normalisation of the signed-magnitude sum.
  logic [ACC_M_W:0]    sum;
  logic                sum_sign, n_sign, n_ovf;
  logic [LZ_W-1:0]     lz;
  logic [EXP_W-1:0]    sh, max_sh, n_exp;
  logic [ACC_M_W-1:0]  n_mant;

  bfp16_lzc #(.W(ACC_M_W + 1), .CW(LZ_W)) u_lzc (
    .din   (sum),
    .count (lz)
  );

  always_comb begin
    if (a_sign == b_sign) begin
      sum      = {1'b0, a_mant} + {1'b0, b_mant};
      sum_sign = a_sign;
    end else if (a_mant >= b_mant) begin
      sum      = {1'b0, a_mant} - {1'b0, b_mant};
      sum_sign = a_sign;
    end else begin
      sum      = {1'b0, b_mant} - {1'b0, a_mant};
      sum_sign = b_sign;
    end
    n_sign = sum_sign;
    n_ovf  = 1'b0;
    sh     = '0;
    max_sh = r_exp - 8'd1;
    n_mant = sum[ACC_M_W-1:0];
    n_exp  = r_exp;
    if (sum[ACC_M_W]) begin
      n_mant = sum[ACC_M_W:1];
      n_exp  = r_exp + 8'd1;
      n_ovf  = (r_exp == EXP_MAX - 8'd1);
    end else if (sum == '0) begin
      n_mant = '0;
      n_exp  = '0;
      n_sign = 1'b0;
    end else begin
      // lz counts the carry bit too; the shift is capped so the exponent
      // bottoms out at the denormal effective exponent of 1.
      sh = 8'(lz) - 8'd1;
      if (sh > max_sh) sh = max_sh;
      n_mant = sum[ACC_M_W-1:0] << sh;
      n_exp  = n_mant[ACC_M_W-1] ? (r_exp - sh) : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_data <= '0;
      lat_last <= 1'b0;
      acc_sign <= 1'b0;
      acc_exp  <= '0;
      acc_mant <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      a_mant   <= '0;
      b_mant   <= '0;
      r_exp    <= '0;
      nan_flag <= 1'b0;
      inf_flag <= 1'b0;
      inf_sign <= 1'b0;
      count    <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (in_valid) begin
            lat_data <= in_data;
            lat_last <= in_last;
          end
        end
        S_ALIGN: begin
          a_sign <= acc_sign;
          a_mant <= al_acc;
          b_sign <= op_sign;
          b_mant <= al_op;
          r_exp  <= al_exp;
          if (op_nan) begin
            nan_flag <= 1'b1;
          end else if (op_inf) begin
            if (inf_flag && (inf_sign != op_sign)) nan_flag <= 1'b1;
            inf_flag <= 1'b1;
            inf_sign <= op_sign;
          end
        end
        S_NORM: begin
          if (n_ovf) begin
            if (inf_flag && (inf_sign != n_sign)) nan_flag <= 1'b1;
            inf_flag <= 1'b1;
            inf_sign <= n_sign;
          end else begin
            acc_sign <= n_sign;
            acc_exp  <= n_exp;
            acc_mant <= n_mant;
          end
          if (count != '1) count <= count + 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            acc_sign <= 1'b0;
            acc_exp  <= '0;
            acc_mant <= '0;
            nan_flag <= 1'b0;
            inf_flag <= 1'b0;
            inf_sign <= 1'b0;
            count    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (nan_flag)      out_data = QNAN;
    else if (inf_flag) out_data = inf_sign ? NINF : PINF;
    else               out_data = {acc_sign, acc_exp, acc_mant[ACC_M_W-2 -: FRAC_W]};
  end

  assign out_count = count;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_bfp16_accum.sv
// Directed bench for bfp16_accum: two-term vector table plus hand-written
// sequences for latency, output stall, mid-vector reset and count saturation.
module tb_bfp16_accum;
  import bfp16_pkg::*;

  localparam int CNT_W = 12;
  localparam int NVEC  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [CNT_W-1:0]  out_count;
  state_t            dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [27:0] exp_q[$];

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [15:0]      exp_data;
    logic [CNT_W-1:0] exp_count;
  } vec_t;
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  bfp16_accum #(.ACC_M_W(16), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which the term was accepted.
  task automatic send(input logic [15:0] d, input logic last);
    int budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready) check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'b0;
  endtask

  task automatic get_result(input string name);
    int budget = 0;
    logic [27:0] exp_v;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 28'h0;
    if (out_valid) begin
      check({name, "_data"}, 32'(out_data), 32'(exp_v[15:0]));
      check({name, "_count"}, 32'(out_count), 32'(exp_v[27:16]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{16'h3F80, 16'h4000, 16'h4040, 12'd2};
    vecs[1]  = '{16'h3F80, 16'hBF80, 16'h0000, 12'd2};
    vecs[2]  = '{16'h7F80, 16'hFF80, 16'hFFFF, 12'd2};
    vecs[3]  = '{16'h7F00, 16'h7F00, 16'h7F80, 12'd2};
    vecs[4]  = '{16'h3F80, 16'h0000, 16'h3F80, 12'd2};
    vecs[5]  = '{16'h4040, 16'hBF80, 16'h4000, 12'd2};
    vecs[6]  = '{16'h3F80, 16'h3B80, 16'h3F80, 12'd2};
    vecs[7]  = '{16'hFF80, 16'h3F80, 16'hFF80, 12'd2};
    vecs[8]  = '{16'h7FC1, 16'h3F80, 16'hFFFF, 12'd2};
    vecs[9]  = '{16'h0040, 16'h0040, 16'h0080, 12'd2};
    vecs[10] = '{16'h0060, 16'h8020, 16'h0040, 12'd2};
    vecs[11] = '{16'hC000, 16'h3F80, 16'hBF80, 12'd2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_WAIT));

    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back({vecs[i].exp_count, vecs[i].exp_data});
      send(vecs[i].a, 1'b0);
      send(vecs[i].b, 1'b1);
      get_result($sformatf("vec%0d", i));
    end

    // Latency: last sampled at edge k, out_valid first sampled high at k+3.
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    check("lat_k1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_k2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_k3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_data", i), 32'(out_data), 32'h4040);
      check($sformatf("stall%0d_count", i), 32'(out_count), 32'd2);
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("taken_in_ready", 32'(in_ready), 32'd1);
    check("taken_out_valid", 32'(out_valid), 32'd0);
    check("taken_out_count", 32'(out_count), 32'd0);
    check("taken_out_data", 32'(out_data), 32'h0);
    exp_q.push_back({12'd1, 16'h3F80});
    send(16'h3F80, 1'b1);
    get_result("restart");

    exp_q.push_back({12'd5, 16'h40A0});
    for (int i = 0; i < 5; i++) send(16'h3F80, i == 4);
    get_result("five_ones");

    // Reset while the first term of a vector is in S_NORM.
    send(16'h3F80, 1'b0);
    check("mid_state_align", 32'(dbg_state), 32'(S_ALIGN));
    tick();
    check("mid_state_norm", 32'(dbg_state), 32'(S_NORM));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h0);
    exp_q.push_back({12'd1, 16'h4000});
    send(16'h4000, 1'b1);
    get_result("after_rst");

    // Term counter saturates; signed zeros still count and sum to +0.
    exp_q.push_back({12'hFFF, 16'h0000});
    for (int i = 0; i < 4100; i++) send((i % 2 == 0) ? 16'h0000 : 16'h8000, i == 4099);
    get_result("count_sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
